// File: rtl/fsm_mux_pkg.sv
// Shared types and defaults for the deterministic stochastic-number generator.
package fsm_mux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_mux_state_e;

    localparam int N_BITS_DEF = 4;

endpackage

// File: rtl/fsm_mux_sel.sv
// Priority MUX: the lowest set bit k of cnt selects x[N_BITS-1-k]; cnt==0 selects 0.
module fsm_mux_sel
    import fsm_mux_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEF
) (
    input  logic [N_BITS-1:0] cnt_i,
    input  logic [N_BITS-1:0] x_i,
    output logic              sel_o
);

    logic [N_BITS-1:0] seen;     // seen[gi]: some cnt bit below gi is set
    logic [N_BITS-1:0] lowest;   // one-hot lowest set bit of cnt
    logic [N_BITS-1:0] x_rev;    // x bit-reversed so that lowest[k] lines up with x[N_BITS-1-k]

    assign seen[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < N_BITS; gi++) begin : g_seen
            assign seen[gi] = seen[gi-1] | cnt_i[gi-1];
        end
        for (genvar gi = 0; gi < N_BITS; gi++) begin : g_pick
            assign lowest[gi] = cnt_i[gi] & ~seen[gi];
            assign x_rev[gi]  = x_i[N_BITS-1-gi];
        end
    endgenerate

    assign sel_o = |(lowest & x_rev);

endmodule

// File: rtl/fsm_mux.sv
// Stochastic-number generator: free-running counter plus priority MUX turns a binary value into a unipolar bitstream.
module fsm_mux
    import fsm_mux_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEF
) (
    input  logic              i_clk_fsm_mux,
    input  logic              i_rst_fsm_mux,
    input  logic [N_BITS-1:0] i_x_bn,
    input  logic              i_start_fsm_mux,
    input  logic              i_stop_fsm_mux,
    output logic              o_sn_bit
);

    fsm_mux_state_e    state_q, state_d;
    logic [N_BITS-1:0] cnt_q, cnt_d;
    logic [N_BITS-1:0] x_q, x_d;
    logic              sel;

    // Start beats stop; a start while running restarts the stream with the new value.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        if (i_start_fsm_mux) begin
            state_d = RUN;
            cnt_d   = '0;
            x_d     = i_x_bn;
        end else if (i_stop_fsm_mux) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk_fsm_mux) begin
        if (i_rst_fsm_mux) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
        end
    end

    fsm_mux_sel #(
        .N_BITS (N_BITS)
    ) u_sel (
        .cnt_i (cnt_q),
        .x_i   (x_q),
        .sel_o (sel)
    );

    assign o_sn_bit = (state_q == RUN) & sel;

endmodule

// File: tb/tb_fsm_mux.sv
// Self-checking bench for fsm_mux: directed streams, sweep, reset/restart cases and a random soak.
module tb_fsm_mux;

    localparam int N = 4;
    localparam int P = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] x_in;
    logic         start;
    logic         stop;
    logic         sn_bit;

    int vectors = 0;
    int errors  = 0;

    // Reference model state: is a stream running, which value, which position in the period.
    bit running = 0;
    int m_x     = 0;
    int m_pos   = 0;

    fsm_mux dut (
        .i_clk_fsm_mux   (clk),
        .i_rst_fsm_mux   (rst),
        .i_x_bn          (x_in),
        .i_start_fsm_mux (start),
        .i_stop_fsm_mux  (stop),
        .o_sn_bit        (sn_bit)
    );

    always #5 clk = ~clk;

    // Position p (p>0) has 2**k as its largest power-of-two divisor; that slot carries x bit N-1-k.
    function automatic logic ref_bit(input int x, input int p);
        int k;
        int c;
        if (p == 0) return 1'b0;
        k = 0;
        c = p;
        while (c % 2 == 0) begin
            c = c / 2;
            k++;
        end
        return logic'((x >> (N - 1 - k)) & 1);
    endfunction

    function automatic logic model_out();
        return running ? ref_bit(m_x, m_pos) : 1'b0;
    endfunction

    // One clock: drive inputs, advance the model, then check the output just after the edge.
    task automatic cycle(input logic r, input logic s, input logic p, input int x, input string tag);
        logic exp_b;
        rst   = r;
        start = s;
        stop  = p;
        x_in  = x[N-1:0];
        @(posedge clk);
        if (r) begin
            running = 0; m_pos = 0; m_x = 0;
        end else if (s) begin
            running = 1; m_pos = 0; m_x = x;
        end else if (p) begin
            running = 0; m_pos = 0;
        end else if (running) begin
            m_pos = (m_pos + 1) % P;
        end
        #1;
        exp_b = model_out();
        vectors++;
        assert (sn_bit === exp_b) else begin
            errors++;
            $error("FAIL %s: o_sn_bit=%b expected %b (x=%0d pos=%0d)", tag, sn_bit, exp_b, m_x, m_pos);
        end
        rst = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    // Start a stream, capture one period (cnt 0 first, leftmost), stop, and check output is 0 afterwards.
    task automatic stream(input int x, input bit chk_pat, input logic [P-1:0] pat);
        logic [P-1:0] cap;
        int           ones;
        cap  = '0;
        ones = 0;
        for (int i = 0; i < P; i++) begin
            if (i == 0) cycle(1'b0, 1'b1, 1'b0, x, "stream_start");
            else        cycle(1'b0, 1'b0, 1'b0, $urandom_range(0, P - 1), "stream_bit");
            cap = {cap[P-2:0], sn_bit};
            ones += int'(sn_bit);
        end
        vectors++;
        assert (ones === x) else begin
            errors++;
            $error("FAIL ones_count: got %0d expected %0d", ones, x);
        end
        if (chk_pat) begin
            vectors++;
            assert (cap === pat) else begin
                errors++;
                $error("FAIL pattern x=%0d: got %b expected %b", x, cap, pat);
            end
        end
        cycle(1'b0, 1'b0, 1'b1, $urandom_range(0, P - 1), "after_stop");
        $display("stream x=%0d bits=%b ones=%0d", x, cap, ones);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; x_in = '0;

        cycle(1'b1, 1'b0, 1'b0, 9, "reset");
        cycle(1'b1, 1'b1, 1'b1, 9, "reset_priority");
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, $urandom_range(0, P - 1), "idle");

        stream(0,  1'b1, 16'h0000);
        stream(15, 1'b1, 16'h7FFF);
        stream(8,  1'b1, 16'h5555);
        stream(4,  1'b1, 16'h2222);
        stream(1,  1'b1, 16'h0080);

        for (int v = 0; v < P; v++) stream(v, 1'b0, '0);

        // Reset in the middle of an x=15 stream, at cnt=5.
        cycle(1'b0, 1'b1, 1'b0, 15, "rst_mid_start");
        for (int i = 1; i <= 5; i++) cycle(1'b0, 1'b0, 1'b0, 15, "rst_mid_run");
        cycle(1'b1, 1'b0, 1'b0, 15, "rst_mid_reset");
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0, $urandom_range(0, P - 1), "rst_mid_idle");
        $display("reset mid-stream x=15 at cnt=5 done");

        // Restart while running, then start+stop together: both restart with x=3.
        cycle(1'b0, 1'b1, 1'b0, 9, "restart_first");
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 9, "restart_run");
        cycle(1'b0, 1'b1, 1'b0, 3, "restart_new");
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, $urandom_range(0, P - 1), "restart_run2");
        cycle(1'b0, 1'b1, 1'b1, 3, "start_stop_both");
        for (int i = 0; i < 2 * P; i++) cycle(1'b0, 1'b0, 1'b0, $urandom_range(0, P - 1), "restart_xchg");
        cycle(1'b0, 1'b0, 1'b1, 0, "restart_stop");
        $display("restart and start+stop with x=3 done");

        // Random soak over all control combinations.
        for (int i = 0; i < 400; i++) begin
            cycle(logic'($urandom_range(0, 49) == 0),
                  logic'($urandom_range(0, 11) == 0),
                  logic'($urandom_range(0, 19) == 0),
                  $urandom_range(0, P - 1), "random");
        end
        $display("random soak of 400 cycles done");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
